// File: rtl/ascon_hash_arbiter_pkg.sv
// Shared types and constants for the Ascon hash-core arbiter.
// Imported by the interface, the round-robin picker and the arbiter top.
package ascon_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    WAIT_HASH,
    DONE
  } arb_state_t;

  localparam int WORD_BITS = 64;
  localparam int HASH_BITS = 256;
  localparam int CNT_BITS  = 16;

endpackage

// File: rtl/ascon_hash_arbiter_if.sv
// Requester-side and core-side bundle of the hash arbiter.
// The arbiter uses the slave view; the surrounding requesters and core use master.
interface ascon_hash_arbiter_if #(
  parameter int N_REQ     = 2,
  parameter int HASH_BITS = 256
);
  import ascon_arb_pkg::*;

  logic [N_REQ-1:0]           req;
  logic [N_REQ*WORD_BITS-1:0] req_msg;
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_last;
  logic [N_REQ-1:0]           req_ack;
  logic [N_REQ-1:0]           grant;
  logic [N_REQ-1:0]           done;
  logic [N_REQ-1:0]           err;
  logic [HASH_BITS-1:0]       hash_out;

  logic [WORD_BITS-1:0]       core_msg;
  logic                       core_start;
  logic                       core_valid;
  logic                       core_last;
  logic                       core_busy;
  logic [HASH_BITS-1:0]       core_hash;
  logic                       core_ready;
  logic                       core_abort;

  modport slave (
    input  req, req_msg, req_valid, req_last, core_busy, core_hash, core_ready,
    output req_ack, grant, done, err, hash_out,
           core_msg, core_start, core_valid, core_last, core_abort
  );

  modport master (
    output req, req_msg, req_valid, req_last, core_busy, core_hash, core_ready,
    input  req_ack, grant, done, err, hash_out,
           core_msg, core_start, core_valid, core_last, core_abort
  );

endinterface

// File: rtl/ascon_hash_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from ptr+1 (wrapping)
// and returns the first requesting index as both one-hot and binary.
module ascon_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             any_req
);

  always_comb begin : p_pick
    int cand;
    cand       = 0;
    winner     = '0;
    winner_idx = '0;
    any_req    = 1'b0;
    // The last previous owner sits at ptr, so it is visited last.
    for (int off = 1; off <= N_REQ; off++) begin
      cand = (int'(ptr) + off) % N_REQ;
      if (!any_req && req[cand]) begin
        any_req    = 1'b1;
        winner_idx = IDX_W'(cand);
      end
    end
    if (any_req) begin
      winner[winner_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ascon_hash_arbiter.sv
// Shares one Ascon hash core between N_REQ requesters, round-robin per message.
// Optional STREAM idle timeout with core abort: define ASCON_ARB_TIMEOUT_EN.
module ascon_hash_arbiter #(
  parameter int N_REQ     = 2,
  parameter int HASH_BITS = ascon_arb_pkg::HASH_BITS,
  parameter int TIMEOUT   = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  ascon_hash_arbiter_if.slave  bus
);
  import ascon_arb_pkg::*;

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("ascon_hash_arbiter: N_REQ must be 2..8 and TIMEOUT 1..65535");
  end

  arb_state_t           state_q;
  arb_state_t           state_d;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     owner_q;
  logic [N_REQ-1:0]     grant_q;
  logic [HASH_BITS-1:0] hash_q;

  logic [N_REQ-1:0]     pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic [WORD_BITS-1:0] owner_msg;
  logic                 owner_valid;
  logic                 owner_last;
  logic                 accept;
  logic                 timeout_hit;

  logic                 start_c;
  logic                 valid_c;
  logic                 last_c;
  logic [WORD_BITS-1:0] msg_c;
  logic [N_REQ-1:0]     ack_c;
  logic [N_REQ-1:0]     done_c;

  ascon_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (bus.req),
    .ptr        (ptr_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any_req    (pick_any)
  );

  always_comb begin
    owner_msg = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_msg = bus.req_msg[i*WORD_BITS +: WORD_BITS];
      end
    end
  end

  assign owner_valid = bus.req_valid[owner_q];
  assign owner_last  = bus.req_last[owner_q];
  assign accept      = (state_q == STREAM) && owner_valid && !bus.core_busy;

`ifdef ASCON_ARB_TIMEOUT_EN
  logic [CNT_BITS-1:0] idle_cnt_q;

  // Counts consecutive STREAM cycles with no accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else if (state_q == START || accept) begin
      idle_cnt_q <= '0;
    end else if (state_q == STREAM) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  // Fires on the TIMEOUT-th idle cycle, i.e. while the count still reads TIMEOUT-1.
  assign timeout_hit = (state_q == STREAM) && !accept &&
                       (idle_cnt_q == CNT_BITS'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    valid_c = 1'b0;
    last_c  = 1'b0;
    msg_c   = '0;
    ack_c   = '0;
    done_c  = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = START;
        end
      end
      START: begin
        start_c = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        msg_c   = owner_msg;
        valid_c = owner_valid;
        last_c  = owner_valid && owner_last;
        ack_c   = accept ? grant_q : '0;
        if (accept && owner_last) begin
          state_d = WAIT_HASH;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      WAIT_HASH: begin
        if (bus.core_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_c  = grant_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ownership, fairness pointer and digest register; ptr only moves when a job ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= IDX_W'(N_REQ - 1);
      owner_q <= '0;
      grant_q <= '0;
      hash_q  <= '0;
    end else begin
      if (state_q == IDLE && pick_any) begin
        grant_q <= pick_onehot;
        owner_q <= pick_idx;
      end
      if (state_q == WAIT_HASH && bus.core_ready) begin
        hash_q <= bus.core_hash;
      end
      if (state_q == DONE || timeout_hit) begin
        ptr_q   <= owner_q;
        grant_q <= '0;
      end
    end
  end

  assign bus.grant      = grant_q;
  assign bus.req_ack    = ack_c;
  assign bus.done       = done_c;
  assign bus.err        = timeout_hit ? grant_q : '0;
  assign bus.hash_out   = hash_q;
  assign bus.core_msg   = msg_c;
  assign bus.core_start = start_c;
  assign bus.core_valid = valid_c;
  assign bus.core_last  = last_c;
  assign bus.core_abort = timeout_hit;

endmodule

// File: tb/tb_ascon_hash_arbiter.sv
// Directed self-checking bench for ascon_hash_arbiter (N_REQ=2, TIMEOUT=8).
// The stall section checks abort behaviour when ASCON_ARB_TIMEOUT_EN is defined.
module tb_ascon_hash_arbiter;
  import ascon_arb_pkg::*;

  localparam logic [255:0] DIG_AB = {32{8'hAB}};
  localparam logic [255:0] DIG0   = {64{4'h5}};
  localparam logic [255:0] DIG1   = {64{4'hC}};

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   doneOrder[$];

  ascon_hash_arbiter_if #(.N_REQ(2), .HASH_BITS(256)) bus ();

  ascon_hash_arbiter #(
    .N_REQ     (2),
    .HASH_BITS (256),
    .TIMEOUT   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] v,
                               input logic [1:0] l, input logic [63:0] m0,
                               input logic [63:0] m1);
    bus.req       = r;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_msg   = {m1, m0};
    #1;
  endtask

  task automatic clearInputs();
    bus.core_busy  = 1'b0;
    bus.core_ready = 1'b0;
    bus.core_hash  = '0;
    applyStimulus(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Requester/core environment: requester i sends words base_i+k, the core
  // answers 3 cycles after the last word with a per-requester digest.
  task automatic serve(input int jobs0, input int jobs1, input int nwords,
                       input int busyAt, input int busyLen, input bit bubble,
                       input bit noise1);
    int jobsLeft[2];
    int wordIdx[2];
    int acks, starts, cyc, busyLeft, busyCycles, readyWait, idx;
    bit busyUsed, inWait;
    logic [1:0]  r, v, l;
    logic [63:0] m[2];
    jobsLeft = '{jobs0, jobs1};
    wordIdx  = '{0, 0};
    acks = 0; starts = 0; cyc = 0; busyLeft = 0; busyCycles = 0; readyWait = 0;
    busyUsed = 1'b0; inWait = 1'b0;
    doneOrder.delete();
    while ((jobsLeft[0] + jobsLeft[1]) > 0 && cyc < 400) begin
      step();
      cyc++;
      for (int i = 0; i < 2; i++) begin
        r[i] = jobsLeft[i] > 0;
        v[i] = r[i] && !(bubble && i == 0 && (cyc % 2 == 1));
        l[i] = v[i] && (wordIdx[i] == nwords - 1);
        m[i] = (i == 0 ? 64'h1000 : 64'h2000) + 64'(wordIdx[i]);
        if (noise1 && i == 1 && !r[i]) begin
          v[i] = (cyc % 2 == 0);
          m[i] = 64'hDEAD_BEEF;
        end
      end
      bus.core_busy  = busyLeft > 0;
      bus.core_ready = inWait && readyWait == 0;
      bus.core_hash  = (bus.grant == 2'b10) ? DIG1 : DIG0;
      applyStimulus(r, v, l, m[0], m[1]);
      if (bus.core_start) starts++;
      checkOutput("ack_owner_only", bus.req_ack & ~bus.grant, 0);
      if (bus.core_busy) begin
        busyCycles++;
        checkOutput("busy_no_ack", bus.req_ack, 0);
        checkOutput("busy_msg_stable", bus.core_msg, m[bus.grant == 2'b10 ? 1 : 0]);
        busyLeft--;
      end
      if (inWait) begin
        if (bus.core_ready) inWait = 1'b0;
        else readyWait--;
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.req_ack[i]) begin
          checkOutput("stream_word", bus.core_msg, m[i]);
          acks++;
          if (wordIdx[i] == nwords - 1) begin
            inWait    = 1'b1;
            readyWait = 3;
          end
          wordIdx[i]++;
          if (!busyUsed && acks == busyAt) begin
            busyLeft = busyLen;
            busyUsed = 1'b1;
          end
        end
      end
      if (bus.done != 2'b00) begin
        idx = (bus.done == 2'b10) ? 1 : 0;
        doneOrder.push_back(idx);
        checkOutput("done_hash", bus.hash_out, idx ? DIG1 : DIG0);
        checkOutput("done_words", wordIdx[idx], nwords);
        jobsLeft[idx]--;
        wordIdx[idx] = 0;
      end
    end
    checkOutput("serve_in_budget", cyc < 400, 1);
    checkOutput("start_count", starts, jobs0 + jobs1);
    checkOutput("ack_count", acks, (jobs0 + jobs1) * nwords);
    if (busyAt > 0) checkOutput("busy_cycles", busyCycles, busyLen);
    step();
    clearInputs();
  endtask

  initial begin
    int ackCount;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clearInputs();

    // Reset state
    checkOutput("rst_grant", bus.grant, 0);
    checkOutput("rst_ack", bus.req_ack, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_core_start", bus.core_start, 0);
    checkOutput("rst_core_valid", bus.core_valid, 0);
    checkOutput("rst_core_abort", bus.core_abort, 0);
    checkOutput("rst_hash", bus.hash_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single job, words 1,2,3: req seen in IDLE, core_start on the next cycle
    $display("[TB] single job");
    step(); applyStimulus(2'b01, 2'b01, 2'b00, 64'd1, 64'd0);
    checkOutput("j1_idle_start", bus.core_start, 0);
    checkOutput("j1_idle_grant", bus.grant, 0);
    step(); applyStimulus(2'b01, 2'b01, 2'b00, 64'd1, 64'd0);
    checkOutput("j1_start_pulse", bus.core_start, 1);
    checkOutput("j1_start_grant", bus.grant, 2'b01);
    checkOutput("j1_start_novalid", bus.core_valid, 0);
    step(); applyStimulus(2'b01, 2'b01, 2'b00, 64'd1, 64'd0);
    checkOutput("j1_w1_ack", bus.req_ack, 2'b01);
    checkOutput("j1_w1_msg", bus.core_msg, 64'd1);
    checkOutput("j1_w1_start_low", bus.core_start, 0);
    step(); applyStimulus(2'b01, 2'b01, 2'b00, 64'd2, 64'd0);
    checkOutput("j1_w2_ack", bus.req_ack, 2'b01);
    checkOutput("j1_w2_msg", bus.core_msg, 64'd2);
    checkOutput("j1_w2_last", bus.core_last, 0);
    step(); applyStimulus(2'b01, 2'b01, 2'b01, 64'd3, 64'd0);
    checkOutput("j1_w3_ack", bus.req_ack, 2'b01);
    checkOutput("j1_w3_last", bus.core_last, 1);
    ackCount = 0;
    for (int k = 0; k < 10; k++) begin
      step(); applyStimulus(2'b01, 2'b00, 2'b00, 64'd0, 64'd0);
      if (bus.req_ack != 2'b00 || bus.core_valid) ackCount++;
    end
    checkOutput("j1_wait_quiet", ackCount, 0);
    step();
    bus.core_ready = 1'b1;
    bus.core_hash  = DIG_AB;
    applyStimulus(2'b01, 2'b00, 2'b00, 64'd0, 64'd0);
    checkOutput("j1_ready_nodone", bus.done, 0);
    step();
    bus.core_ready = 1'b0;
    bus.core_hash  = '0;
    applyStimulus(2'b00, 2'b00, 2'b00, 64'd0, 64'd0);
    checkOutput("j1_done", bus.done, 2'b01);
    checkOutput("j1_hash", bus.hash_out, DIG_AB);
    step(); applyStimulus(2'b00, 2'b00, 2'b00, 64'd0, 64'd0);
    checkOutput("j1_done_once", bus.done, 0);
    checkOutput("j1_grant_clear", bus.grant, 0);
    // core_ready while idle must not touch the digest
    step();
    bus.core_ready = 1'b1;
    bus.core_hash  = DIG1;
    applyStimulus(2'b00, 2'b00, 2'b00, 64'd0, 64'd0);
    step();
    bus.core_ready = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00, 64'd0, 64'd0);
    checkOutput("idle_ready_ignored", bus.hash_out, DIG_AB);

    // Contention from reset: 0 then 1, then 0,1,0,1 with both held
    $display("[TB] contention");
    doReset();
    serve(1, 1, 2, 0, 0, 1'b0, 1'b0);
    checkOutput("rr1_len", doneOrder.size(), 2);
    checkOutput("rr1_first", doneOrder[0], 0);
    checkOutput("rr1_second", doneOrder[1], 1);
    serve(2, 2, 2, 0, 0, 1'b0, 1'b0);
    checkOutput("rr2_len", doneOrder.size(), 4);
    checkOutput("rr2_o0", doneOrder[0], 0);
    checkOutput("rr2_o1", doneOrder[1], 1);
    checkOutput("rr2_o2", doneOrder[2], 0);
    checkOutput("rr2_o3", doneOrder[3], 1);

    // Backpressure: core busy for 4 cycles after the second word
    $display("[TB] backpressure");
    serve(1, 0, 4, 2, 4, 1'b0, 1'b0);

    // Owner bubbles while requester 1 flaps valid without requesting
    $display("[TB] bubble and non-owner valid");
    serve(1, 0, 4, 0, 0, 1'b1, 1'b1);
    checkOutput("bubble_owner", doneOrder[0], 0);

    // Reset in the middle of a requester-1 stream
    $display("[TB] reset mid-stream");
    step(); applyStimulus(2'b10, 2'b10, 2'b00, 64'd0, 64'h100);
    step(); applyStimulus(2'b10, 2'b10, 2'b00, 64'd0, 64'h100);
    checkOutput("mr_grant1", bus.grant, 2'b10);
    step(); applyStimulus(2'b10, 2'b10, 2'b00, 64'd0, 64'h100);
    checkOutput("mr_w1_ack", bus.req_ack, 2'b10);
    step(); applyStimulus(2'b10, 2'b10, 2'b00, 64'd0, 64'h101);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_grant0", bus.grant, 0);
    checkOutput("mr_ack0", bus.req_ack, 0);
    checkOutput("mr_valid0", bus.core_valid, 0);
    checkOutput("mr_msg0", bus.core_msg, 0);
    checkOutput("mr_hash0", bus.hash_out, 0);
    clearInputs();
    step();
    rst_n = 1'b1;
    serve(1, 1, 2, 0, 0, 1'b0, 1'b0);
    checkOutput("mr_fresh_first", doneOrder[0], 0);
    checkOutput("mr_fresh_second", doneOrder[1], 1);

    // Owner stalls after one word while requester 1 waits
    $display("[TB] stalled owner");
    step(); applyStimulus(2'b11, 2'b01, 2'b00, 64'h200, 64'h300);
    step(); applyStimulus(2'b11, 2'b01, 2'b00, 64'h200, 64'h300);
    checkOutput("st_grant0", bus.grant, 2'b01);
    step(); applyStimulus(2'b11, 2'b01, 2'b00, 64'h200, 64'h300);
    checkOutput("st_w1_ack", bus.req_ack, 2'b01);
`ifdef ASCON_ARB_TIMEOUT_EN
    ackCount = 0;
    for (int k = 1; k <= 8; k++) begin
      step(); applyStimulus(2'b11, 2'b00, 2'b00, 64'h201, 64'h300);
      if (k < 8 && (bus.err != 2'b00 || bus.core_abort)) ackCount++;
    end
    checkOutput("to_early_quiet", ackCount, 0);
    checkOutput("to_err", bus.err, 2'b01);
    checkOutput("to_abort", bus.core_abort, 1);
    checkOutput("to_hash_kept", bus.hash_out, DIG1);
    step(); applyStimulus(2'b11, 2'b00, 2'b00, 64'h201, 64'h300);
    checkOutput("to_err_pulse", bus.err, 0);
    checkOutput("to_idle_grant", bus.grant, 0);
    step(); applyStimulus(2'b11, 2'b00, 2'b00, 64'h201, 64'h300);
    checkOutput("to_next_grant", bus.grant, 2'b10);
    checkOutput("to_next_start", bus.core_start, 1);
`else
    ackCount = 0;
    for (int k = 0; k < 20; k++) begin
      step(); applyStimulus(2'b11, 2'b00, 2'b00, 64'h201, 64'h300);
      if (bus.err != 2'b00 || bus.core_abort) ackCount++;
    end
    checkOutput("st_no_err", ackCount, 0);
    step(); applyStimulus(2'b11, 2'b01, 2'b01, 64'h201, 64'h300);
    checkOutput("st_still_stream", bus.req_ack, 2'b01);
    checkOutput("st_still_owner", bus.grant, 2'b01);
`endif
    doReset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
